// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a counter-based clock divider with handshake-loaded
// terminal count and glitch-free stop. Define CLKDIV_BURST_EN to add fixed-length burst mode.
module clk_div_ctrl #(
  parameter int CNT_W        = 25,
  parameter int DEFAULT_HALF = 24999999,
  parameter int MIN_HALF     = 1
) (
  input  logic             clk_50mhz,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
`ifdef CLKDIV_BURST_EN
  input  logic [15:0]      burst_len,
  output logic             done,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] half_reg;
  logic             clk_out_reg;
  logic             tick_reg;
  logic             cfg_err_reg;

  logic             at_terminal;
  logic             cfg_accept;
  logic             cfg_legal;

`ifdef CLKDIV_BURST_EN
  logic [15:0]      burst_len_reg;
  logic [15:0]      rise_cnt_reg;
  logic             done_reg;
  logic             burst_end;
`endif

  assign at_terminal = (count_reg == half_reg);
  assign cfg_accept  = cfg_valid && (state_reg == IDLE);
  assign cfg_legal   = (cfg_half >= CNT_W'(MIN_HALF));

`ifdef CLKDIV_BURST_EN
  // Burst is over once the programmed number of rising edges has been produced.
  assign burst_end = (burst_len_reg != 16'd0) && (rise_cnt_reg == burst_len_reg);
`endif

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      half_reg      <= CNT_W'(DEFAULT_HALF);
      clk_out_reg   <= 1'b0;
      tick_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
`ifdef CLKDIV_BURST_EN
      burst_len_reg <= 16'd0;
      rise_cnt_reg  <= 16'd0;
      done_reg      <= 1'b0;
`endif
    end else begin
      tick_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
`ifdef CLKDIV_BURST_EN
      done_reg    <= 1'b0;
`endif

      if (cfg_accept) begin
        if (cfg_legal) begin
          half_reg <= cfg_half;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          count_reg   <= '0;
          clk_out_reg <= 1'b0;
          if (start) begin
            state_reg     <= RUN;
`ifdef CLKDIV_BURST_EN
            burst_len_reg <= burst_len;
            rise_cnt_reg  <= 16'd0;
`endif
          end
        end

        RUN: begin
          if (stop && !clk_out_reg) begin
            // Low phase: halting now cannot shorten a high pulse.
            state_reg <= IDLE;
            count_reg <= '0;
          end else if (at_terminal) begin
            count_reg   <= '0;
            clk_out_reg <= ~clk_out_reg;
            if (!clk_out_reg) begin
              tick_reg <= 1'b1;
`ifdef CLKDIV_BURST_EN
              if (burst_len_reg != 16'd0) begin
                rise_cnt_reg <= rise_cnt_reg + 16'd1;
              end
`endif
            end else if (stop) begin
              state_reg <= IDLE;
`ifdef CLKDIV_BURST_EN
            end else if (burst_end) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
`endif
            end
          end else begin
            count_reg <= count_reg + CNT_W'(1);
            if (stop) begin
              state_reg <= STOPPING;
            end
          end
        end

        STOPPING: begin
          // Finish the current high phase, then park low.
          if (at_terminal) begin
            count_reg   <= '0;
            clk_out_reg <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg   <= IDLE;
          count_reg   <= '0;
          clk_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign state     = state_reg;
  assign clk_out   = clk_out_reg;
  assign tick      = tick_reg;
  assign cfg_err   = cfg_err_reg;
`ifdef CLKDIV_BURST_EN
  assign done      = done_reg;
`endif

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the team's counter-based clock divider. It owns a terminal-count register loaded through a valid/ready handshake, and sequences the divider through start, run and a glitch-free stop. It outputs the divided clock plus a one-cycle tick aligned to each divided rising edge. It sits between the 50 MHz board clock and any slow observation or stepping logic that needs a reconfigurable rate without resynthesis.

Parameters:
CNT_W, 25, width of the half-period counter and terminal-count register
DEFAULT_HALF, 24999999, terminal count loaded at reset (1 Hz from 50 MHz)
MIN_HALF, 1, smallest legal terminal count; smaller requests are rejected

Ports:
clk_50mhz  input  1  board clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  new terminal count offered
cfg_half  input  CNT_W  requested terminal count (half period in cycles, minus 1)
cfg_ready  output  1  controller can accept configuration
cfg_err  output  1  one-cycle pulse: offered value rejected
start  input  1  level-sampled request to begin dividing
stop  input  1  level-sampled request to halt dividing
clk_out  output  1  divided clock (registered)
tick  output  1  one-cycle pulse in the cycle clk_out becomes 1
busy  output  1  high whenever state is not IDLE
state  output  2  IDLE=0, RUN=1, STOPPING=2

Behaviour:
- Reset, async on rst_n low:
  - state IDLE, count 0, half_reg DEFAULT_HALF.
  - clk_out 0, tick 0, cfg_err 0, busy 0, cfg_ready 1.
- cfg_ready is 1 exactly when state==IDLE.
- Configuration handshake: transfer occurs when cfg_valid && cfg_ready on a rising edge.
  - If cfg_half >= MIN_HALF, half_reg is updated at that edge.
  - Otherwise half_reg is unchanged and cfg_err pulses high for the following cycle.
  - cfg_valid outside IDLE is ignored (no error).
- IDLE:
  - start=1 moves to RUN next edge; count 0, clk_out 0.
  - stop is ignored.
  - If start and a config transfer occur on the same edge, the new half_reg is used by this run.
- RUN:
  - On each edge, if count==half_reg, count goes to 0 and clk_out toggles; otherwise count increments.
  - The first clk_out rise occurs half_reg+1 edges after the start edge.
  - Period is 2*(half_reg+1) cycles, 50% duty.
- tick is registered and high exactly in the cycles where clk_out transitions 0->1.
- stop=1 in RUN:
  - If clk_out==0, go to IDLE next edge; count cleared, clk_out stays 0.
  - If clk_out==1, go to STOPPING.
- STOPPING:
  - Counting continues unchanged.
  - At the toggle edge, clk_out goes to 0, count goes to 0, and state goes to IDLE.
  - start and stop are ignored.
  - No truncated high phase ever appears on clk_out.
- start and stop together: in IDLE start wins; in RUN stop wins.
- Count arithmetic is CNT_W bits unsigned. count never exceeds half_reg, so there is no wrap.
- Reset mid-run: clk_out drops to 0 immediately (asynchronous), and any partial phase is discarded.

Optional Feature:
Macro CLKDIV_BURST_EN.
- Enabled:
  - Adds input burst_len (16 bits) and output done (1 bit).
  - burst_len is sampled on the start edge.
  - If nonzero, RUN counts tick pulses. After the burst_len-th high phase completes (clk_out falling), the state goes directly to IDLE, and done pulses for one cycle in the cycle after that edge.
  - burst_len==0 means free-run.
  - A manual stop during a burst behaves as normal stop, and done is not asserted.
- Disabled:
  - No extra ports; behaviour exactly as above, free-running only.

Test Plan:
- Reset with no config, start held 1 cycle -> no tick within 24999999 cycles; state==RUN, busy==1, cfg_ready==0 (spot-check by forcing observation window).
- cfg_half=3 accepted in IDLE, then start -> first tick 4 edges after start edge; clk_out period 8 cycles, high 4/low 4; tick once per 8 cycles.
- cfg_half=0 offered in IDLE -> cfg_err one-cycle pulse, half_reg retains 3; then cfg_half=5 offered while RUN -> cfg_ready=0, no update, no cfg_err.
- half=3: stop asserted 1 cycle after a tick (clk_out=1) -> STOPPING for 3 more cycles, clk_out falls with count==3 rollover, IDLE same edge; stop while clk_out=0 -> IDLE next edge, clk_out remains 0.
- rst_n pulsed low mid high phase -> clk_out 0, state IDLE, cfg_ready 1 without waiting for a clock edge.
- CLKDIV_BURST_EN, half=1, burst_len=3 -> exactly 3 ticks at 4-cycle spacing, IDLE at third falling edge, done high 1 cycle later; burst_len=0 -> free-run unchanged.
